motion_bbox: RTL and testbench

MOTION_BBOX -- requirements
Module: motion_bbox

---
 rtl/motion_pkg.sv | 11 +
 rtl/seq_divider.sv | 42 ++++
 rtl/motion_bbox.sv | 115 +++++++++++
 tb/tb_motion_bbox.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/motion_pkg.sv
// motion_pkg: shared widths and FSM states for motion_bbox (DIV state only with MOTION_BBOX_CENTROID_EN)
package motion_pkg;
  localparam int COORD_W = 11;
  localparam int CNT_W = 19;
  localparam int SUM_W = 29;
`ifdef MOTION_BBOX_CENTROID_EN
  typedef enum logic [1:0] {ACC, DIV, PRESENT} state_t;
`else
  typedef enum logic [1:0] {ACC, PRESENT} state_t;
`endif
endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring divider producing one quotient bit per cycle
module seq_divider
  import motion_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [SUM_W-1:0]   i_dividend,
  input  logic [CNT_W-1:0]   i_divisor,
  output logic [COORD_W-1:0] o_quotient,
  output logic               o_done
);
  logic [SUM_W-1:0] r_q;
  logic [CNT_W-1:0] r_d, r_r;
  logic [CNT_W:0] w_rem;
  logic [4:0] r_n;
  logic r_busy, w_ge;
  assign w_rem = {r_r, r_q[SUM_W-1]};
  assign w_ge = w_rem >= {1'b0, r_d};
  assign o_done = r_busy && r_n == '0;
  assign o_quotient = r_q[COORD_W-1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_q <= '0;
      r_d <= '0;
      r_r <= '0;
      r_n <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_q <= i_dividend;
      r_d <= i_divisor;
      r_r <= '0;
      r_n <= 5'(SUM_W);
      r_busy <= 1'b1;
    end else if (o_done) begin
      r_busy <= 1'b0;
    end else if (r_busy) begin
      r_r <= w_ge ? CNT_W'(w_rem - {1'b0, r_d}) : w_rem[CNT_W-1:0];
      r_q <= {r_q[SUM_W-2:0], w_ge};
      r_n <= r_n - 5'd1;
    end
endmodule

// File: rtl/motion_bbox.sv
// motion_bbox: per-frame bounding box, pixel count and centroid (centroid only with MOTION_BBOX_CENTROID_EN)
module motion_bbox
  import motion_pkg::*;
#(
  parameter int H_IMG_RES = 640,
  parameter int V_IMG_RES = 480,
  parameter int MIN_PIX_COUNT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] hpos,
  input  logic [COORD_W-1:0] vpos,
  input  logic               in_pix,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [COORD_W-1:0] x_min,
  output logic [COORD_W-1:0] x_max,
  output logic [COORD_W-1:0] y_min,
  output logic [COORD_W-1:0] y_max,
  output logic [CNT_W-1:0]   pix_count,
  output logic               empty,
  output logic [COORD_W-1:0] cx,
  output logic [COORD_W-1:0] cy,
  output logic [7:0]         drop_cnt
);
  logic w_hit, w_end, w_snap, w_empty;
  logic [COORD_W-1:0] r_x_min, r_x_max, r_y_min, r_y_max;
  logic [COORD_W-1:0] w_x_min, w_x_max, w_y_min, w_y_max;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  state_t r_state, w_state;
  assign w_hit = in_pix && hpos < COORD_W'(H_IMG_RES) && vpos < COORD_W'(V_IMG_RES);
  assign w_end = hpos == COORD_W'(H_IMG_RES - 1) && vpos == COORD_W'(V_IMG_RES - 1);
  assign w_x_min = w_hit && hpos < r_x_min ? hpos : r_x_min;
  assign w_x_max = w_hit && hpos > r_x_max ? hpos : r_x_max;
  assign w_y_min = w_hit && vpos < r_y_min ? vpos : r_y_min;
  assign w_y_max = w_hit && vpos > r_y_max ? vpos : r_y_max;
  assign w_cnt = r_cnt + CNT_W'(w_hit);
  assign w_empty = w_cnt < CNT_W'(MIN_PIX_COUNT);
  assign w_snap = w_end && r_state == ACC;
  assign res_valid = r_state == PRESENT;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_x_min <= '1;
      r_x_max <= '0;
      r_y_min <= '1;
      r_y_max <= '0;
      r_cnt <= '0;
    end else begin
      r_x_min <= w_end ? '1 : w_x_min;
      r_x_max <= w_end ? '0 : w_x_max;
      r_y_min <= w_end ? '1 : w_y_min;
      r_y_max <= w_end ? '0 : w_y_max;
      r_cnt <= w_end ? '0 : w_cnt;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      x_min <= '0;
      x_max <= '0;
      y_min <= '0;
      y_max <= '0;
      pix_count <= '0;
      empty <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (w_snap) begin
        x_min <= w_empty ? '0 : w_x_min;
        x_max <= w_empty ? '0 : w_x_max;
        y_min <= w_empty ? '0 : w_y_min;
        y_max <= w_empty ? '0 : w_y_max;
        pix_count <= w_cnt;
        empty <= w_empty;
      end
      if (w_end && r_state != ACC && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= ACC;
    else r_state <= w_state;
`ifdef MOTION_BBOX_CENTROID_EN
  logic [SUM_W-1:0] r_sum_x, r_sum_y, w_sum_x, w_sum_y;
  logic [COORD_W-1:0] w_qx, w_qy;
  logic w_skip, w_start, w_done_x, w_done_y, w_done;
  assign w_sum_x = r_sum_x + (w_hit ? SUM_W'(hpos) : '0);
  assign w_sum_y = r_sum_y + (w_hit ? SUM_W'(vpos) : '0);
  assign w_skip = w_empty || w_cnt == '0;
  assign w_start = w_snap && !w_skip;
  assign w_done = w_done_x && w_done_y;
  seq_divider u_div_x (.clk, .rst_n, .i_start(w_start), .i_dividend(w_sum_x), .i_divisor(w_cnt), .o_quotient(w_qx), .o_done(w_done_x));
  seq_divider u_div_y (.clk, .rst_n, .i_start(w_start), .i_dividend(w_sum_y), .i_divisor(w_cnt), .o_quotient(w_qy), .o_done(w_done_y));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sum_x <= '0;
      r_sum_y <= '0;
    end else begin
      r_sum_x <= w_end ? '0 : w_sum_x;
      r_sum_y <= w_end ? '0 : w_sum_y;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {cx, cy} <= '0;
    else if (w_snap) {cx, cy} <= '0;
    else if (r_state == DIV && w_done) {cx, cy} <= {w_qx, w_qy};
  always_comb begin
    w_state = r_state;
    w_state = r_state == ACC ? (w_snap ? (w_skip ? PRESENT : DIV) : ACC) :
              r_state == DIV ? (w_done ? PRESENT : DIV) :
              (res_ready ? ACC : PRESENT);
  end
`else
  assign cx = '0;
  assign cy = '0;
  always_comb begin
    w_state = r_state;
    w_state = r_state == ACC ? (w_snap ? PRESENT : ACC) : (res_ready ? ACC : PRESENT);
  end
`endif
endmodule

// File: tb/tb_motion_bbox.sv
// tb_motion_bbox: directed vector bench for motion_bbox on a reduced 20x30 raster
module tb_motion_bbox;
  localparam int H = 20;
  localparam int V = 30;
`ifdef MOTION_BBOX_CENTROID_EN
  localparam bit CEN = 1'b1;
`else
  localparam bit CEN = 1'b0;
`endif
  typedef struct {int xmn, xmx, ymn, ymx, cnt, emp, cx, cy;} res_t;
  typedef struct {int mode; res_t e16; res_t e1;} vec_t;
  logic clk = 1'b0, rst_n, res_ready, in_pix;
  logic [10:0] hpos, vpos;
  logic vld[2], emp[2];
  logic [10:0] xmn[2], xmx[2], ymn[2], ymx[2], cxo[2], cyo[2];
  logic [18:0] cnt[2];
  logic [7:0] drp[2];
  int checks = 0, errors = 0, cyc = 0, t_end = 0;
  logic lat_v;
  vec_t vecs[5];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  motion_bbox #(.H_IMG_RES(H), .V_IMG_RES(V), .MIN_PIX_COUNT(16)) d16 (
    .clk, .rst_n, .hpos, .vpos, .in_pix, .res_valid(vld[0]), .res_ready,
    .x_min(xmn[0]), .x_max(xmx[0]), .y_min(ymn[0]), .y_max(ymx[0]), .pix_count(cnt[0]),
    .empty(emp[0]), .cx(cxo[0]), .cy(cyo[0]), .drop_cnt(drp[0]));
  motion_bbox #(.H_IMG_RES(H), .V_IMG_RES(V), .MIN_PIX_COUNT(1)) d1 (
    .clk, .rst_n, .hpos, .vpos, .in_pix, .res_valid(vld[1]), .res_ready,
    .x_min(xmn[1]), .x_max(xmx[1]), .y_min(ymn[1]), .y_max(ymx[1]), .pix_count(cnt[1]),
    .empty(emp[1]), .cx(cxo[1]), .cy(cyo[1]), .drop_cnt(drp[1]));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic chk_res(input int i, input string tag, input res_t e);
    chk($sformatf("%s[%0d] x_min", tag, i), 32'(xmn[i]), e.xmn);
    chk($sformatf("%s[%0d] x_max", tag, i), 32'(xmx[i]), e.xmx);
    chk($sformatf("%s[%0d] y_min", tag, i), 32'(ymn[i]), e.ymn);
    chk($sformatf("%s[%0d] y_max", tag, i), 32'(ymx[i]), e.ymx);
    chk($sformatf("%s[%0d] pix_count", tag, i), 32'(cnt[i]), e.cnt);
    chk($sformatf("%s[%0d] empty", tag, i), 32'(emp[i]), e.emp);
    chk($sformatf("%s[%0d] cx", tag, i), 32'(cxo[i]), CEN ? e.cx : 0);
    chk($sformatf("%s[%0d] cy", tag, i), 32'(cyo[i]), CEN ? e.cy : 0);
  endtask
  function automatic logic pix(input int mode, input int h, input int v);
    if (h >= H || v >= V) return 1'b1;
    case (mode)
      1: return h == 10 && v == 5;
      2: return h >= 10 && h <= 13 && v >= 20 && v <= 23;
      3: return 1'b1;
      4: return h == H - 1 && v == V - 1;
      default: return 1'b0;
    endcase
  endfunction
  task automatic run_frame(input int mode, input int rst_line);
    for (int v = 0; v <= V; v++)
      for (int h = 0; h < H + 2; h++) begin
        if (rst_line >= 0 && v == rst_line && h == H) begin
          rst_n = 1'b0;
          #1;
          for (int i = 0; i < 2; i++) begin
            chk($sformatf("async rst[%0d] res_valid", i), 32'(vld[i]), 0);
            chk($sformatf("async rst[%0d] x_min", i), 32'(xmn[i]), 0);
            chk($sformatf("async rst[%0d] pix_count", i), 32'(cnt[i]), 0);
            chk($sformatf("async rst[%0d] drop_cnt", i), 32'(drp[i]), 0);
          end
        end
        if (rst_line >= 0 && v == rst_line + 1 && h == 0) rst_n = 1'b1;
        hpos = 11'(h);
        vpos = 11'(v);
        in_pix = pix(mode, h, v);
        @(posedge clk);
        #1;
        if (h == H - 1 && v == V - 1) begin
          lat_v = vld[0];
          t_end = cyc;
        end
      end
  endtask
  task automatic wait_valid(input string tag);
    int n = 0;
    while (!(vld[0] && vld[1]) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, " res_valid"}, 32'(vld[0] && vld[1]), 1);
    chk({tag, " latency<=34"}, 32'(cyc - t_end + 1 <= 34), 1);
  endtask
  task automatic accept(input string tag);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk({tag, " accepted[0]"}, 32'(vld[0]), 0);
    chk({tag, " accepted[1]"}, 32'(vld[1]), 0);
  endtask
  initial begin
    vecs[0] = '{1, '{0, 0, 0, 0, 1, 1, 0, 0}, '{10, 10, 5, 5, 1, 0, 10, 5}};
    vecs[1] = '{2, '{10, 13, 20, 23, 16, 0, 11, 21}, '{10, 13, 20, 23, 16, 0, 11, 21}};
    vecs[2] = '{3, '{0, 19, 0, 29, 600, 0, 9, 14}, '{0, 19, 0, 29, 600, 0, 9, 14}};
    vecs[3] = '{4, '{0, 0, 0, 0, 1, 1, 0, 0}, '{19, 19, 29, 29, 1, 0, 19, 29}};
    vecs[4] = '{0, '{0, 0, 0, 0, 0, 1, 0, 0}, '{0, 0, 0, 0, 0, 1, 0, 0}};
    rst_n = 1'b0;
    res_ready = 1'b0;
    hpos = 11'(H);
    vpos = 11'd0;
    in_pix = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk_res(i, "reset", '{0, 0, 0, 0, 0, 0, 0, 0});
      chk($sformatf("reset[%0d] res_valid", i), 32'(vld[i]), 0);
      chk($sformatf("reset[%0d] drop_cnt", i), 32'(drp[i]), 0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      run_frame(vecs[k].mode, -1);
      chk($sformatf("vec%0d valid after end", k), 32'(lat_v), CEN ? vecs[k].e16.emp : 1);
      wait_valid($sformatf("vec%0d", k));
      chk_res(0, $sformatf("vec%0d", k), vecs[k].e16);
      chk_res(1, $sformatf("vec%0d", k), vecs[k].e1);
      accept($sformatf("vec%0d", k));
    end
    run_frame(2, -1);
    wait_valid("drop");
    repeat (3) run_frame(3, -1);
    chk("drop res_valid held", 32'(vld[0]), 1);
    chk("drop drop_cnt[0]", 32'(drp[0]), 3);
    chk("drop drop_cnt[1]", 32'(drp[1]), 3);
    chk_res(0, "held", vecs[1].e16);
    accept("drop");
    chk("drop_cnt after accept", 32'(drp[0]), 3);
    run_frame(3, 9);
    wait_valid("midrst");
    chk_res(0, "midrst", '{0, 19, 10, 29, 400, 0, 9, 19});
    chk_res(1, "midrst", '{0, 19, 10, 29, 400, 0, 9, 19});
    accept("midrst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
